maindec_vseq: RTL and testbench



---
 rtl/ctrl_pkg.sv | 44 ++++
 rtl/opcode_decode.sv | 69 ++++++
 rtl/maindec_vseq.sv | 118 +++++++++++
 tb/tb_maindec_vseq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, control word type and helpers for the main decoder
package ctrl_pkg;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_FP   = 6'b000100;
   localparam logic [5:0] OP_VALU = 6'b001100;
   localparam logic [5:0] OP_ADDI = 6'b010000;
   localparam logic [5:0] OP_SW   = 6'b010001;
   localparam logic [5:0] OP_LW   = 6'b010010;
   localparam logic [5:0] OP_SWFP = 6'b010101;
   localparam logic [5:0] OP_LWFP = 6'b010110;
   localparam logic [5:0] OP_VST  = 6'b011101;
   localparam logic [5:0] OP_VLD  = 6'b011110;
   localparam logic [5:0] OP_BEQ  = 6'b100000;
   localparam logic [5:0] OP_BLT  = 6'b100001;
   localparam logic [5:0] OP_J    = 6'b100010;
   localparam logic [5:0] OP_VSET = 6'b111111;

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_EQ   = 2'b01;
   localparam logic [1:0] BR_LT   = 2'b10;

   // Field order matches the control outputs of maindec_vseq
   typedef struct packed {
      logic       regWrite;
      logic       VregWrite;
      logic       memtoReg;
      logic       VmemtoReg;
      logic       memWrite;
      logic       memData;
      logic       memSrc;
      logic       ALUSrc;
      logic       regDst;
      logic       jump;
      logic [1:0] branch;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

   function automatic logic is_vector(input logic [5:0] op);
      return (op == OP_VALU) || (op == OP_VST) || (op == OP_VLD) || (op == OP_VSET);
   endfunction

endpackage

// File: rtl/opcode_decode.sv
// rtl/opcode_decode.sv - combinational opcode to control word decode
module opcode_decode
   import ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic       vector_en,
   output ctrl_t      ctrl,
   output logic       illegal
);

   // Unknown and disabled opcodes decode to NOP with illegal raised
   always_comb begin
      ctrl    = CTRL_NOP;
      illegal = 1'b0;
      if (!vector_en && is_vector(op)) begin
         illegal = 1'b1;
      end else begin
         case (op)
            OP_ADD, OP_FP: begin
               ctrl.regWrite = 1'b1;
               ctrl.regDst   = 1'b1;
            end
            OP_ADDI: begin
               ctrl.regWrite = 1'b1;
               ctrl.ALUSrc   = 1'b1;
            end
            OP_VALU: begin
               ctrl.VregWrite = 1'b1;
               ctrl.regDst    = 1'b1;
            end
            OP_SW, OP_SWFP: begin
               ctrl.memWrite = 1'b1;
               ctrl.ALUSrc   = 1'b1;
            end
            OP_LW: begin
               ctrl.regWrite = 1'b1;
               ctrl.memtoReg = 1'b1;
               ctrl.ALUSrc   = 1'b1;
            end
            OP_LWFP: begin
               ctrl.VregWrite = 1'b1;
               ctrl.VmemtoReg = 1'b1;
               ctrl.ALUSrc    = 1'b1;
            end
            OP_VLD: begin
               ctrl.VregWrite = 1'b1;
               ctrl.VmemtoReg = 1'b1;
               ctrl.ALUSrc    = 1'b1;
               ctrl.memSrc    = 1'b1;
            end
            OP_VST: begin
               ctrl.memWrite = 1'b1;
               ctrl.memData  = 1'b1;
               ctrl.memSrc   = 1'b1;
               ctrl.ALUSrc   = 1'b1;
            end
            OP_BEQ:  ctrl.branch = BR_EQ;
            OP_BLT:  ctrl.branch = BR_LT;
            OP_J:    ctrl.jump   = 1'b1;
            OP_VSET: begin
               ctrl.VregWrite = 1'b1;
               ctrl.ALUSrc    = 1'b1;
            end
            default: illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/maindec_vseq.sv
// rtl/maindec_vseq.sv - registered main decoder with vector memory beat sequencing
module maindec_vseq
   import ctrl_pkg::*;
#(
   parameter  int LANES     = 4,
   parameter  int MEM_PORTS = 1,
   parameter  int VECTOR_EN = 1,
   localparam int BEATS     = LANES / MEM_PORTS,
   localparam int IW        = $clog2(LANES)
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [5:0]    op,
   input  logic          valid_i,
   input  logic          flush_i,
   output logic          stall_o,
   output logic          regWrite,
   output logic          VregWrite,
   output logic          memtoReg,
   output logic          VmemtoReg,
   output logic          memWrite,
   output logic          memData,
   output logic          memSrc,
   output logic          ALUSrc,
   output logic          regDst,
   output logic          jump,
   output logic [1:0]    branch,
   output logic [IW-1:0] elem_idx,
   output logic          vmem_first,
   output logic          vmem_last,
   output logic          illegal_o
);

   typedef enum logic {IDLE, VMEM} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] cnt_q, cnt_d;
   logic [5:0]    op_q;
   logic [IW-1:0] cur_cnt;
   logic          vmem_op, seq_cont, last_beat;
   ctrl_t         dec_ctrl, ctrl_q, ctrl_d;
   logic          dec_ill, ill_d, first_d, last_d;
   logic [IW-1:0] idx_d;

   opcode_decode u_dec (
      .op        (op),
      .vector_en (VECTOR_EN != 0),
      .ctrl      (dec_ctrl),
      .illegal   (dec_ill)
   );

   assign vmem_op   = valid_i && !dec_ill && ((op == OP_VLD) || (op == OP_VST));
   // A sequence only continues while the same op stays presented; anything else restarts at beat 0
   assign seq_cont  = (state_q == VMEM) && valid_i && (op == op_q);
   assign cur_cnt   = seq_cont ? cnt_q : '0;
   assign last_beat = (cur_cnt == IW'(BEATS - 1));
   assign stall_o   = rst_n && !flush_i && vmem_op && !last_beat;

   // Beat counter / state next-value and registered control word contents
   always_comb begin
      state_d = IDLE;
      cnt_d   = '0;
      ctrl_d  = CTRL_NOP;
      ill_d   = 1'b0;
      first_d = 1'b0;
      last_d  = 1'b0;
      idx_d   = '0;
      if (!flush_i && valid_i) begin
         ctrl_d = dec_ctrl;
         ill_d  = dec_ill;
         if (vmem_op) begin
            first_d = (cur_cnt == '0);
            last_d  = last_beat;
            idx_d   = IW'(int'(cur_cnt) * MEM_PORTS);
            if (!last_beat) begin
               state_d = VMEM;
               cnt_d   = cur_cnt + IW'(1);
            end
         end
      end
   end

   // State, counter and output register, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         ctrl_q     <= CTRL_NOP;
         illegal_o  <= 1'b0;
         vmem_first <= 1'b0;
         vmem_last  <= 1'b0;
         elem_idx   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op;
         ctrl_q     <= ctrl_d;
         illegal_o  <= ill_d;
         vmem_first <= first_d;
         vmem_last  <= last_d;
         elem_idx   <= idx_d;
      end
   end

   assign regWrite  = ctrl_q.regWrite;
   assign VregWrite = ctrl_q.VregWrite;
   assign memtoReg  = ctrl_q.memtoReg;
   assign VmemtoReg = ctrl_q.VmemtoReg;
   assign memWrite  = ctrl_q.memWrite;
   assign memData   = ctrl_q.memData;
   assign memSrc    = ctrl_q.memSrc;
   assign ALUSrc    = ctrl_q.ALUSrc;
   assign regDst    = ctrl_q.regDst;
   assign jump      = ctrl_q.jump;
   assign branch    = ctrl_q.branch;

endmodule

// File: tb/tb_maindec_vseq.sv
// tb/tb_maindec_vseq.sv - directed self-checking bench for maindec_vseq
module tb_maindec_vseq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid_i = 1'b0;
   logic       flush_i = 1'b0;
   logic [5:0] op = 6'b0;

   int nchk = 0;
   int nerr = 0;

   // control bits: regWrite VregWrite memtoReg VmemtoReg memWrite memData memSrc ALUSrc regDst jump branch[1:0]
   wire [11:0] c4, c8, c0;
   wire [1:0]  e4, e0;
   wire [2:0]  e8;
   wire        f4, l4, i4, s4;
   wire        f8, l8, i8, s8;
   wire        f0, l0, i0, s0;

   localparam logic [11:0] K_NOP  = 12'h000;
   localparam logic [11:0] K_ADDI = 12'h810;
   localparam logic [11:0] K_ADD  = 12'h808;
   localparam logic [11:0] K_VLD  = 12'h530;
   localparam logic [11:0] K_VST  = 12'h0F0;
   localparam logic [11:0] K_VALU = 12'h408;
   localparam logic [11:0] K_BEQ  = 12'h001;
   localparam logic [11:0] K_BLT  = 12'h002;
   localparam logic [11:0] K_J    = 12'h004;

   always #5 clk = ~clk;

   maindec_vseq #(.LANES(4), .MEM_PORTS(1), .VECTOR_EN(1)) u4 (
      .clk(clk), .rst_n(rst_n), .op(op), .valid_i(valid_i), .flush_i(flush_i), .stall_o(s4),
      .regWrite(c4[11]), .VregWrite(c4[10]), .memtoReg(c4[9]), .VmemtoReg(c4[8]),
      .memWrite(c4[7]), .memData(c4[6]), .memSrc(c4[5]), .ALUSrc(c4[4]), .regDst(c4[3]),
      .jump(c4[2]), .branch(c4[1:0]), .elem_idx(e4), .vmem_first(f4), .vmem_last(l4), .illegal_o(i4));

   maindec_vseq #(.LANES(8), .MEM_PORTS(2), .VECTOR_EN(1)) u8 (
      .clk(clk), .rst_n(rst_n), .op(op), .valid_i(valid_i), .flush_i(flush_i), .stall_o(s8),
      .regWrite(c8[11]), .VregWrite(c8[10]), .memtoReg(c8[9]), .VmemtoReg(c8[8]),
      .memWrite(c8[7]), .memData(c8[6]), .memSrc(c8[5]), .ALUSrc(c8[4]), .regDst(c8[3]),
      .jump(c8[2]), .branch(c8[1:0]), .elem_idx(e8), .vmem_first(f8), .vmem_last(l8), .illegal_o(i8));

   maindec_vseq #(.LANES(4), .MEM_PORTS(1), .VECTOR_EN(0)) u0 (
      .clk(clk), .rst_n(rst_n), .op(op), .valid_i(valid_i), .flush_i(flush_i), .stall_o(s0),
      .regWrite(c0[11]), .VregWrite(c0[10]), .memtoReg(c0[9]), .VmemtoReg(c0[8]),
      .memWrite(c0[7]), .memData(c0[6]), .memSrc(c0[5]), .ALUSrc(c0[4]), .regDst(c0[3]),
      .jump(c0[2]), .branch(c0[1:0]), .elem_idx(e0), .vmem_first(f0), .vmem_last(l0), .illegal_o(i0));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0]  bop [3];
      logic [11:0] bexp [3];
      bop[0] = 6'b100000; bexp[0] = K_BEQ;
      bop[1] = 6'b100001; bexp[1] = K_BLT;
      bop[2] = 6'b100010; bexp[2] = K_J;

      // reset state, stall forced low while in reset
      tick(); tick();
      op = 6'b011110; valid_i = 1'b1; #1;
      chk("rst_ctrl", 32'(c4), 32'(K_NOP));
      chk("rst_misc", 32'({e4, f4, l4, i4}), 32'd0);
      chk("rst_stall", 32'(s4), 32'd0);
      valid_i = 1'b0; op = 6'b0;
      #1 rst_n = 1'b1;

      // addi then idle
      tick();
      op = 6'b010000; valid_i = 1'b1; #1;
      chk("addi_stall", 32'(s4), 32'd0);
      tick();
      chk("addi_ctrl", 32'(c4), 32'(K_ADDI));
      chk("addi_misc", 32'({e4, f4, l4, i4}), 32'd0);
      chk("addi_ctrl_nov", 32'(c0), 32'(K_ADDI));
      valid_i = 1'b0; #1;
      tick();
      chk("idle_ctrl", 32'(c4), 32'(K_NOP));
      chk("idle_ill", 32'(i4), 32'd0);

      // vld held for four cycles, LANES=4 MEM_PORTS=1 (u8 runs four beats of two)
      op = 6'b011110; valid_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("vld_stall%0d", k), 32'(s4), 32'(k != 3));
         chk($sformatf("vld_novec_stall%0d", k), 32'(s0), 32'd0);
         tick();
         chk($sformatf("vld_ctrl%0d", k), 32'(c4), 32'(K_VLD));
         chk($sformatf("vld_idx%0d", k), 32'(e4), k);
         chk($sformatf("vld_first%0d", k), 32'(f4), 32'(k == 0));
         chk($sformatf("vld_last%0d", k), 32'(l4), 32'(k == 3));
         chk($sformatf("vld8_idx%0d", k), 32'(e8), 2 * k);
         chk($sformatf("vld_novec%0d", k), 32'({c0, i0}), 32'd1);
      end
      op = 6'b000000; #1;
      chk("add_stall", 32'(s4), 32'd0);
      tick();
      chk("add_ctrl", 32'(c4), 32'(K_ADD));
      chk("add_misc", 32'({e4, f4, l4, i4}), 32'd0);

      // branches and jump
      for (int b = 0; b < 3; b++) begin
         op = bop[b]; #1;
         tick();
         chk($sformatf("br_ctrl%0d", b), 32'(c4), 32'(bexp[b]));
         chk($sformatf("br_ill%0d", b), 32'(i4), 32'd0);
      end

      // vst on LANES=8 MEM_PORTS=2, flushed at cnt=2
      op = 6'b011101; #1;
      tick();
      chk("vst_idx0", 32'(e8), 32'd0);
      chk("vst_ctrl", 32'(c8), 32'(K_VST));
      tick();
      chk("vst_idx1", 32'(e8), 32'd2);
      flush_i = 1'b1; #1;
      chk("flush_stall", 32'(s8), 32'd0);
      tick();
      chk("flush_ctrl", 32'(c8), 32'(K_NOP));
      chk("flush_misc", 32'({e8, f8, l8, i8}), 32'd0);
      flush_i = 1'b0; #1;
      chk("restart_stall", 32'(s8), 32'd1);
      tick();
      chk("restart_idx", 32'(e8), 32'd0);
      chk("restart_first", 32'(f8), 32'd1);
      valid_i = 1'b0; #1;
      tick();

      // illegal / disabled opcodes
      op = 6'b001100; valid_i = 1'b1; #1;
      chk("valu_nov_stall", 32'(s0), 32'd0);
      tick();
      chk("valu_nov", 32'({c0, i0}), 32'd1);
      chk("valu_vec", 32'({c4, i4}), 32'({K_VALU, 1'b0}));
      op = 6'b101010; #1;
      tick();
      chk("unk4", 32'({c4, i4}), 32'd1);
      chk("unk8", 32'({c8, i8}), 32'd1);
      chk("unk0", 32'({c0, i0}), 32'd1);

      // asynchronous reset in the middle of a vld, at cnt=2
      op = 6'b011110; #1;
      tick(); tick();
      chk("pre_rst_idx", 32'(e4), 32'd1);
      rst_n = 1'b0; #1;
      chk("arst_ctrl", 32'(c4), 32'(K_NOP));
      chk("arst_misc", 32'({e4, f4, l4, i4}), 32'd0);
      chk("arst_stall", 32'(s4), 32'd0);
      #1 rst_n = 1'b1; #1;
      chk("post_rst_stall", 32'(s4), 32'd1);
      tick();
      chk("post_rst_idx", 32'(e4), 32'd0);
      chk("post_rst_first", 32'(f4), 32'd1);
      valid_i = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
